// File: rtl/tlb_param.sv
// Parametrised MIPS-style TLB: two registered search ports, combinational read port,
// hardware Random counter. Define TLB_FLUSH_EN to build the invalidate-all sweep engine.
module tlb_param #(
    parameter  int ENTRY_NUM = 16,
    localparam int IDXW      = $clog2(ENTRY_NUM)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s0_req,
    input  logic [18:0]     s0_vpn2,
    input  logic            s0_odd_page,
    input  logic [7:0]      s0_asid,
    output logic            s0_rvalid,
    output logic            s0_found,
    output logic [IDXW-1:0] s0_index,
    output logic [19:0]     s0_pfn,
    output logic [2:0]      s0_c,
    output logic            s0_d,
    output logic            s0_v,
    input  logic            s1_req,
    input  logic [18:0]     s1_vpn2,
    input  logic            s1_odd_page,
    input  logic [7:0]      s1_asid,
    output logic            s1_rvalid,
    output logic            s1_found,
    output logic [IDXW-1:0] s1_index,
    output logic [19:0]     s1_pfn,
    output logic [2:0]      s1_c,
    output logic            s1_d,
    output logic            s1_v,
    input  logic            we,
    input  logic [IDXW-1:0] w_index,
    input  logic [18:0]     w_vpn2,
    input  logic [7:0]      w_asid,
    input  logic            w_g,
    input  logic [19:0]     w_pfn0,
    input  logic [2:0]      w_c0,
    input  logic            w_d0,
    input  logic            w_v0,
    input  logic [19:0]     w_pfn1,
    input  logic [2:0]      w_c1,
    input  logic            w_d1,
    input  logic            w_v1,
    input  logic [IDXW-1:0] r_index,
    output logic [18:0]     r_vpn2,
    output logic [7:0]      r_asid,
    output logic            r_g,
    output logic [19:0]     r_pfn0,
    output logic [2:0]      r_c0,
    output logic            r_d0,
    output logic            r_v0,
    output logic [19:0]     r_pfn1,
    output logic [2:0]      r_c1,
    output logic            r_d1,
    output logic            r_v1,
    input  logic [IDXW-1:0] wired,
    output logic [IDXW-1:0] random_index,
    input  logic            flush_req,
    output logic            flush_busy
);
    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } entry_t;

    typedef struct packed {
        logic            found;
        logic [IDXW-1:0] index;
        logic [19:0]     pfn;
        logic [2:0]      c;
        logic            d;
        logic            v;
    } sresp_t;

    localparam logic [IDXW-1:0] LAST = IDXW'(ENTRY_NUM - 1);

    entry_t tlb [ENTRY_NUM];

`ifdef TLB_FLUSH_EN
    typedef enum logic {IDLE, SWEEP} fstate_t;
    fstate_t         state;
    logic [IDXW-1:0] ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: if (flush_req) begin
                    state <= SWEEP;
                    ptr   <= '0;
                end
                SWEEP: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign flush_busy = (state == SWEEP);
`else
    logic unused_flush;
    assign unused_flush = flush_req;
    assign flush_busy   = 1'b0;
`endif

    // The sweep and software writes never coincide because we is blocked while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRY_NUM; i++) tlb[i] <= '0;
        end else begin
            if (we && !flush_busy)
                tlb[w_index] <= {w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
                                 w_pfn1, w_c1, w_d1, w_v1};
`ifdef TLB_FLUSH_EN
            if (state == SWEEP) begin
                tlb[ptr].g  <= 1'b0;
                tlb[ptr].v0 <= 1'b0;
                tlb[ptr].v1 <= 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                random_index <= LAST;
        else if (random_index > wired) random_index <= random_index - 1'b1;
        else                      random_index <= LAST;
    end

    logic [1:0]       sreq;
    logic [1:0][18:0] svpn;
    logic [1:0]       sodd;
    logic [1:0][7:0]  sasid;
    logic [1:0]       vld_pipe;
    sresp_t [1:0]     resp_q;

    assign sreq  = {s1_req, s0_req};
    assign svpn  = {s1_vpn2, s0_vpn2};
    assign sodd  = {s1_odd_page, s0_odd_page};
    assign sasid = {s1_asid, s0_asid};

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [ENTRY_NUM-1:0] match;
        logic                 hit;
        logic [IDXW-1:0]      hidx;
        entry_t               he;

        for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_cmp
            assign match[i] = (tlb[i].vpn2 == svpn[p]) && (tlb[i].g || tlb[i].asid == sasid[p]);
        end

        // Scan downwards so the lowest matching index is the one left standing.
        always_comb begin
            hit  = 1'b0;
            hidx = '0;
            for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
                if (match[i]) begin
                    hit  = 1'b1;
                    hidx = IDXW'(i);
                end
            end
        end
        assign he = tlb[hidx];

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_pipe[p] <= 1'b0;
                resp_q[p]   <= '0;
            end else begin
                vld_pipe[p] <= sreq[p];
                if (sreq[p]) begin
                    if (hit && !flush_busy)
                        resp_q[p] <= sodd[p] ? {1'b1, hidx, he.pfn1, he.c1, he.d1, he.v1}
                                             : {1'b1, hidx, he.pfn0, he.c0, he.d0, he.v0};
                    else
                        resp_q[p] <= '0;
                end
            end
        end
    end

    assign s0_rvalid = vld_pipe[0];
    assign {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v} = resp_q[0];
    assign s1_rvalid = vld_pipe[1];
    assign {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v} = resp_q[1];

    assign {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
            r_pfn1, r_c1, r_d1, r_v1} = tlb[r_index];
endmodule

// File: tb/tb_tlb_param.sv
// Bench for tlb_param: directed cases plus randomized traffic against an array-based model.
module tb_tlb_param;
    localparam int N    = 16;
    localparam int IDXW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic sreq [2];
    logic [18:0] svpn [2];
    logic sodd [2];
    logic [7:0] sasid [2];
    logic orv [2];
    logic ofound [2];
    logic [IDXW-1:0] oidx [2];
    logic [19:0] opfn [2];
    logic [2:0] oc [2];
    logic od [2];
    logic ov [2];
    logic we;
    logic [IDXW-1:0] w_index, r_index, wired, random_index;
    logic [18:0] w_vpn2, r_vpn2;
    logic [7:0] w_asid, r_asid;
    logic w_g, r_g, w_d0, w_v0, w_d1, w_v1, r_d0, r_v0, r_d1, r_v1;
    logic [19:0] w_pfn0, w_pfn1, r_pfn0, r_pfn1;
    logic [2:0] w_c0, w_c1, r_c0, r_c1;
    logic flush_req, flush_busy;

    tlb_param #(.ENTRY_NUM(N)) dut (
        .clk(clk), .reset(reset),
        .s0_req(sreq[0]), .s0_vpn2(svpn[0]), .s0_odd_page(sodd[0]), .s0_asid(sasid[0]),
        .s0_rvalid(orv[0]), .s0_found(ofound[0]), .s0_index(oidx[0]), .s0_pfn(opfn[0]),
        .s0_c(oc[0]), .s0_d(od[0]), .s0_v(ov[0]),
        .s1_req(sreq[1]), .s1_vpn2(svpn[1]), .s1_odd_page(sodd[1]), .s1_asid(sasid[1]),
        .s1_rvalid(orv[1]), .s1_found(ofound[1]), .s1_index(oidx[1]), .s1_pfn(opfn[1]),
        .s1_c(oc[1]), .s1_d(od[1]), .s1_v(ov[1]),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
        .wired(wired), .random_index(random_index),
        .flush_req(flush_req), .flush_busy(flush_busy)
    );

    typedef struct packed {
        logic            f;
        logic [IDXW-1:0] idx;
        logic [19:0]     pfn;
        logic [2:0]      c;
        logic            d;
        logic            v;
    } res_t;

    // Model state: one row of plain fields per entry.
    logic [18:0] m_vpn2 [N];
    logic [7:0]  m_asid [N];
    logic        m_g [N], m_d0 [N], m_v0 [N], m_d1 [N], m_v1 [N];
    logic [19:0] m_pfn0 [N], m_pfn1 [N];
    logic [2:0]  m_c0 [N], m_c1 [N];
    int   m_rnd;
    int   m_flush_left;
    res_t e_res [2];
    logic e_vld [2];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mclear();
        for (int i = 0; i < N; i++) begin
            m_vpn2[i] = '0; m_asid[i] = '0; m_g[i] = 0;
            m_pfn0[i] = '0; m_c0[i] = '0; m_d0[i] = 0; m_v0[i] = 0;
            m_pfn1[i] = '0; m_c1[i] = '0; m_d1[i] = 0; m_v1[i] = 0;
        end
    endtask

    function automatic res_t msearch(input int p);
        res_t r = '0;
        for (int i = 0; i < N; i++) begin
            if (m_vpn2[i] == svpn[p] && (m_g[i] || m_asid[i] == sasid[p])) begin
                r.f   = 1'b1;
                r.idx = IDXW'(i);
                r.pfn = sodd[p] ? m_pfn1[i] : m_pfn0[i];
                r.c   = sodd[p] ? m_c1[i]   : m_c0[i];
                r.d   = sodd[p] ? m_d1[i]   : m_d0[i];
                r.v   = sodd[p] ? m_v1[i]   : m_v0[i];
                return r;
            end
        end
        return r;
    endfunction

    // One clock: predict from the pre-edge model, advance the model, then compare.
    task automatic step();
        res_t nr [2];
        int   nrnd;
        bit   busy;
        busy = (m_flush_left > 0);
        for (int p = 0; p < 2; p++)
            nr[p] = sreq[p] ? (busy ? res_t'(0) : msearch(p)) : e_res[p];
        nrnd = (m_rnd > int'(wired)) ? m_rnd - 1 : N - 1;
        @(posedge clk);
        if (reset) begin
            mclear();
            for (int p = 0; p < 2; p++) begin e_res[p] = '0; e_vld[p] = 0; end
            m_rnd = N - 1;
            m_flush_left = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin e_vld[p] = sreq[p]; e_res[p] = nr[p]; end
            m_rnd = nrnd;
            if (we && !busy) begin
                m_vpn2[w_index] = w_vpn2; m_asid[w_index] = w_asid; m_g[w_index] = w_g;
                m_pfn0[w_index] = w_pfn0; m_c0[w_index] = w_c0; m_d0[w_index] = w_d0; m_v0[w_index] = w_v0;
                m_pfn1[w_index] = w_pfn1; m_c1[w_index] = w_c1; m_d1[w_index] = w_d1; m_v1[w_index] = w_v1;
            end
`ifdef TLB_FLUSH_EN
            if (busy) begin
                int k;
                k = N - m_flush_left;
                m_g[k] = 0; m_v0[k] = 0; m_v1[k] = 0;
                m_flush_left--;
            end else if (flush_req) begin
                m_flush_left = N;
            end
`endif
        end
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            chk(p == 0 ? "s0_rvalid" : "s1_rvalid", 128'(orv[p]), 128'(e_vld[p]));
            chk(p == 0 ? "s0_result" : "s1_result",
                128'({ofound[p], oidx[p], opfn[p], oc[p], od[p], ov[p]}), 128'(e_res[p]));
        end
        chk("random_index", 128'(random_index), 128'(m_rnd));
        chk("flush_busy", 128'(flush_busy), 128'(m_flush_left > 0));
        chk("read_port",
            128'({r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1}),
            128'({m_vpn2[r_index], m_asid[r_index], m_g[r_index], m_pfn0[r_index], m_c0[r_index],
                  m_d0[r_index], m_v0[r_index], m_pfn1[r_index], m_c1[r_index], m_d1[r_index],
                  m_v1[r_index]}));
    endtask

    task automatic wr(input int idx, input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
                      input logic [19:0] pfn0, input logic v0, input logic [19:0] pfn1,
                      input logic [2:0] c1, input logic d1, input logic v1);
        we = 1; w_index = IDXW'(idx); w_vpn2 = vpn2; w_asid = asid; w_g = g;
        w_pfn0 = pfn0; w_c0 = 3'd2; w_d0 = 0; w_v0 = v0;
        w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
    endtask

    task automatic srch(input int p, input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
        sreq[p] = 1; svpn[p] = vpn2; sodd[p] = odd; sasid[p] = asid;
    endtask

    task automatic idle();
        we = 0; flush_req = 0; sreq[0] = 0; sreq[1] = 0;
    endtask

    initial begin
        int exp_seq [7];
        int busy_cnt;
        exp_seq = '{15, 14, 13, 12, 15, 14, 13};
        mclear();
        m_rnd = N - 1; m_flush_left = 0;
        for (int p = 0; p < 2; p++) begin
            e_res[p] = '0; e_vld[p] = 0; svpn[p] = '0; sodd[p] = 0; sasid[p] = '0;
        end
        idle();
        wr(0, '0, '0, 0, '0, 0, '0, '0, 0, 0);
        we = 0; r_index = '0; wired = '0; reset = 1;
        @(negedge clk);
        step(); step();
        reset = 0;
        for (int i = 0; i < N; i++) begin r_index = IDXW'(i); step(); end
        chk("reset_random", 128'(random_index), 128'(15));
        chk("reset_found", 128'({ofound[0], ofound[1]}), 128'(0));

        // Directed hit/miss on idx 3, odd page.
        wr(3, 19'h00012, 8'h05, 0, 20'h11111, 0, 20'hABCDE, 3'd3, 1, 1);
        step(); idle();
        srch(0, 19'h00012, 1, 8'h05); step(); idle();
        chk("hit_lit", 128'({orv[0], ofound[0], oidx[0], opfn[0], oc[0], od[0], ov[0]}),
            128'({1'b1, 1'b1, 4'd3, 20'hABCDE, 3'd3, 1'b1, 1'b1}));
        srch(0, 19'h00012, 1, 8'h06); step(); idle();
        chk("asid_miss_lit", 128'({orv[0], ofound[0]}), 128'(2'b10));

        // Duplicate global tags: lowest index wins; then same-cycle write vs search.
        wr(5, 19'h00777, 8'h01, 1, 20'h55555, 1, 20'h5, 3'd1, 0, 1); step();
        wr(9, 19'h00777, 8'h02, 1, 20'h99999, 1, 20'h9, 3'd1, 0, 1); step(); idle();
        srch(1, 19'h00777, 0, 8'hC3); step(); idle();
        chk("prio_lit", 128'({ofound[1], oidx[1], opfn[1]}), 128'({1'b1, 4'd5, 20'h55555}));
        wr(2, 19'h00333, 8'h00, 1, 20'h22222, 1, 20'h2, 3'd0, 0, 1);
        srch(0, 19'h00333, 0, 8'h44); step(); idle();
        chk("wr_search_same_lit", 128'(ofound[0]), 128'(0));
        srch(0, 19'h00333, 0, 8'h44); step(); idle();
        chk("wr_search_next_lit", 128'({ofound[0], oidx[0]}), 128'({1'b1, 4'd2}));

        // Random counter sequence with wired=12, then Wired raised above the counter.
        wired = 4'd12; reset = 1; step(); reset = 0;
        chk("rnd_seq0", 128'(random_index), 128'(exp_seq[0]));
        for (int i = 1; i < 7; i++) begin
            step();
            chk("rnd_seq", 128'(random_index), 128'(exp_seq[i]));
        end
        wired = 4'd14; step();
        chk("rnd_wired_raise", 128'(random_index), 128'(15));
        wired = 4'd15; step(); step();
        chk("rnd_wired_max", 128'(random_index), 128'(15));

`ifdef TLB_FLUSH_EN
        wired = '0;
        for (int i = 0; i < N; i++) begin
            wr(i, 19'(i + 1), 8'h07, 1, 20'(i + 100), 1, 20'(i + 200), 3'd1, 1, 1); step();
        end
        idle(); flush_req = 1; step(); flush_req = 0;
        busy_cnt = 0;
        for (int i = 0; i < 40 && flush_busy; i++) begin
            busy_cnt++;
            wr(0, 19'h00055, 8'h00, 1, 20'h1, 1, 20'h1, 3'd0, 0, 1);
            srch(1, 19'h00010, 0, 8'h07);
            step();
            chk("busy_search_lit", 128'({orv[1], ofound[1]}), 128'(2'b10));
        end
        idle();
        chk("flush_len_lit", 128'(busy_cnt), 128'(16));
        for (int i = 0; i < N; i++) begin
            r_index = IDXW'(i); step();
            chk("flush_keep_lit", 128'({r_vpn2, r_pfn0, r_g, r_v0, r_v1}),
                128'({19'(i + 1), 20'(i + 100), 3'b000}));
        end
        for (int i = 0; i < N; i++) begin
            wr(i, 19'(i + 1), 8'h07, 1, 20'(i + 100), 1, 20'(i + 200), 3'd1, 1, 1); step();
        end
        idle(); flush_req = 1; step(); flush_req = 0;
        for (int i = 0; i < 6; i++) step();
        reset = 1; step(); reset = 0;
        chk("flush_reset_busy_lit", 128'(flush_busy), 128'(0));
        for (int i = 0; i < N; i++) begin
            r_index = IDXW'(i); step();
            chk("flush_reset_clear_lit", 128'({r_vpn2, r_pfn0, r_pfn1, r_g, r_v0, r_v1}), 128'(0));
        end
`endif

        // Randomized traffic; small tag/asid alphabets so hits and multi-matches happen.
        wired = 4'd3;
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            we = ($urandom_range(0, 2) == 0);
            w_index = IDXW'($urandom_range(0, N - 1));
            w_vpn2 = 19'($urandom_range(16, 19));
            w_asid = 8'($urandom_range(0, 3));
            w_g = ($urandom_range(0, 3) == 0);
            w_pfn0 = 20'($urandom); w_c0 = 3'($urandom); w_d0 = 1'($urandom); w_v0 = 1'($urandom);
            w_pfn1 = 20'($urandom); w_c1 = 3'($urandom); w_d1 = 1'($urandom); w_v1 = 1'($urandom);
            for (int p = 0; p < 2; p++) begin
                sreq[p] = 1'($urandom);
                svpn[p] = 19'($urandom_range(16, 19));
                sodd[p] = 1'($urandom);
                sasid[p] = 8'($urandom_range(0, 3));
            end
            r_index = IDXW'($urandom_range(0, N - 1));
            if ($urandom_range(0, 39) == 0) wired = IDXW'($urandom_range(0, N - 1));
            flush_req = ($urandom_range(0, 149) == 0);
            step();
        end
        idle(); reset = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
